// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_seq
//  Brief    : Sequential shift-add-3 binary-to-BCD converter, one input bit
//             per clock. Drives three registered decimal digits (hundreds,
//             tens, ones) for the display multiplexer and saturates to 999
//             with an overflow flag when the captured value exceeds 999.
//  Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] bin_in,
    output logic                busy,
    output logic                valid,
    output logic                overflow,
    output logic [3:0]          hex0char,
    output logic [3:0]          hex1char,
    output logic [3:0]          hex2char
);

    // Counter must hold IN_WIDTH itself, so size it for IN_WIDTH+1 values.
    localparam int                  c_cnt_w   = $clog2(IN_WIDTH + 1);
    localparam int                  c_nibbles = 5;
    localparam int                  c_bcd_w   = 4 * c_nibbles;
    localparam logic [IN_WIDTH-1:0] c_max_dec = IN_WIDTH'(999);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [IN_WIDTH-1:0]  r_bin;
    logic [c_bcd_w-1:0]   r_bcd;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ovf;

    logic [c_bcd_w-1:0]   w_bcd_adj;
    logic                 w_ovf_final;

    // Add-3 correction on every accumulator nibble that is 5 or more, so the
    // following left shift carries correctly into the next decimal digit.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < c_nibbles; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Final overflow decision: the captured >999 flag, reinforced by any
    // non-zero digit above hundreds (which can only arise from such values).
    always_comb begin
        w_ovf_final = r_ovf | (|r_bcd[c_bcd_w-1:12]);
    end

    // Control FSM and datapath: capture, shift IN_WIDTH times, then publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            hex0char <= 4'd0;
            hex1char <= 4'd0;
            hex2char <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_bin   <= bin_in;
                        r_bcd   <= '0;
                        r_cnt   <= c_cnt_w'(IN_WIDTH);
                        r_ovf   <= (bin_in > c_max_dec);
                        busy    <= 1'b1;
                        valid   <= 1'b0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_bcd <= {w_bcd_adj[c_bcd_w-2:0], r_bin[IN_WIDTH-1]};
                        r_bin <= {r_bin[IN_WIDTH-2:0], 1'b0};
                        r_cnt <= r_cnt - c_cnt_w'(1);
                        // A carry out of the top nibble would also mean >999.
                        r_ovf <= r_ovf | w_bcd_adj[c_bcd_w-1];
                    end else begin
                        // Digits only ever change here, so the display never
                        // shows a partially converted value.
                        overflow <= w_ovf_final;
                        if (w_ovf_final) begin
                            hex0char <= 4'd9;
                            hex1char <= 4'd9;
                            hex2char <= 4'd9;
                        end else begin
                            hex0char <= r_bcd[3:0];
                            hex1char <= r_bcd[7:4];
                            hex2char <= r_bcd[11:8];
                        end
                        busy    <= 1'b0;
                        valid   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    valid   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
